// File: rtl/serial_mul_ctrl_if.sv
// rtl/serial_mul_ctrl_if.sv - handshake and operand-write bundle for serial_mul_ctrl
interface serial_mul_ctrl_if #(
  parameter int WORD_W = 32,
  parameter int PW     = 5
);
  // Touch input side and multiplier completion
  logic              in_valid;
  logic [WORD_W-1:0] in_value;
  logic              in_sel;
  logic              go;
  logic              clr;
  logic              mul_done;

  // Operand register file, multiplier start and display status
  logic              op_we;
  logic              op_sel;
  logic [PW-1:0]     op_idx;
  logic [WORD_W-1:0] op_wdata;
  logic              mul_start;
  logic              in_ready;
  logic              busy;
  logic              res_valid;
  logic              err;
  logic [PW-1:0]     cur_ptr;

  modport master (
    output in_valid, in_value, in_sel, go, clr, mul_done,
    input  op_we, op_sel, op_idx, op_wdata, mul_start,
           in_ready, busy, res_valid, err, cur_ptr
  );

  modport slave (
    input  in_valid, in_value, in_sel, go, clr, mul_done,
    output op_we, op_sel, op_idx, op_wdata, mul_start,
           in_ready, busy, res_valid, err, cur_ptr
  );
endinterface

// File: rtl/serial_mul_ctrl.sv
// rtl/serial_mul_ctrl.sv - operand loading and start/complete/timeout sequencing for the serial multiplier
module serial_mul_ctrl #(
  parameter int WORD_W      = 32,
  parameter int OP_WORDS    = 32,
  parameter int TIMEOUT_CYC = 4096,
  parameter int PW          = $clog2(OP_WORDS)
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  serial_mul_ctrl_if.slave  bus
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(OP_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic              res_valid_q;
  logic              err_q;

  logic              sel_q;
  logic [PW-1:0]     ptr0_q;
  logic [PW-1:0]     ptr1_q;

  logic              op_we_q;
  logic              op_sel_q;
  logic [PW-1:0]     op_idx_q;
  logic [WORD_W-1:0] op_wdata_q;

  logic              accepting;
  logic              accept;
  logic              sel_chg;
  logic [PW-1:0]     base0;
  logic [PW-1:0]     base1;
  logic [PW-1:0]     eff_ptr;
  logic [PW-1:0]     next_ptr;

  // Pointer view after applying an operand-select change seen this cycle
  always_comb begin
    accepting = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);
    accept    = bus.in_valid && accepting && !bus.clr;
    sel_chg   = (bus.in_sel != sel_q);
    base0     = (sel_chg && !bus.in_sel) ? '0 : ptr0_q;
    base1     = (sel_chg &&  bus.in_sel) ? '0 : ptr1_q;
    eff_ptr   = bus.in_sel ? base1 : base0;
    next_ptr  = (eff_ptr == PTR_LAST) ? '0 : eff_ptr + 1'b1;
  end

  // Write pointers: restart on select change, advance on accepted words, zero on abort
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      sel_q  <= 1'b0;
      ptr0_q <= '0;
      ptr1_q <= '0;
    end else begin
      sel_q <= bus.in_sel;
      if (bus.clr) begin
        ptr0_q <= '0;
        ptr1_q <= '0;
      end else begin
        ptr0_q <= base0;
        ptr1_q <= base1;
        if (accept) begin
          if (bus.in_sel) ptr1_q <= next_ptr;
          else            ptr0_q <= next_ptr;
        end
      end
    end
  end

  // Registered operand write port, one pulse per accepted word
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      op_we_q    <= 1'b0;
      op_sel_q   <= 1'b0;
      op_idx_q   <= '0;
      op_wdata_q <= '0;
    end else begin
      op_we_q <= accept;
      if (accept) begin
        op_sel_q   <= bus.in_sel;
        op_idx_q   <= eff_ptr;
        op_wdata_q <= bus.in_value;
      end
    end
  end

  // Sequencing FSM; abort beats everything, completion beats timeout
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else if (bus.clr) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (bus.go) begin
            state_q     <= S_START;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
          end else if (bus.in_valid) begin
            state_q     <= S_IDLE;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
          end
        end
        S_START: begin
          cnt_q <= '0;
          if (bus.mul_done) begin
            state_q     <= S_DONE;
            res_valid_q <= 1'b1;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.mul_done) begin
            state_q     <= S_DONE;
            res_valid_q <= 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_ERR;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.op_we     = op_we_q;
  assign bus.op_sel    = op_sel_q;
  assign bus.op_idx    = op_idx_q;
  assign bus.op_wdata  = op_wdata_q;
  assign bus.mul_start = (state_q == S_START);
  assign bus.busy      = (state_q == S_START) || (state_q == S_WAIT);
  assign bus.in_ready  = accepting;
  assign bus.res_valid = res_valid_q;
  assign bus.err       = err_q;
  assign bus.cur_ptr   = eff_ptr;

endmodule

// File: doc/serial_mul_ctrl.md
# serial_mul_ctrl

Sequencing controller for the 1024×1024-bit serial multiplier. It turns the touchscreen's single-cycle input words into indexed writes to the two 1024-bit operand registers. It then issues a start pulse to the multiplier and tracks completion, with a timeout, so the display logic knows when the 2048-bit product is valid. It sits between the LCD/touch input logic, the operand register file and the multiplier core.

## Interface
- WORD_W, 32, width of one input/operand word
- OP_WORDS, 32, words per operand (1024/WORD_W); pointer width PW = clog2(OP_WORDS) = 5
- TIMEOUT_CYC, 4096, cycles allowed in WAIT before flagging an error

- clk  in  1  system clock; one clock
- resetn  in  1  reset, asynchronous, active-low
- in_valid  in  1  one-cycle pulse: in_value holds a new word
- in_value  in  WORD_W  input word from the touchscreen
- in_sel  in  1  operand select: 0 = In1, 1 = In2
- go  in  1  one-cycle pulse: request a multiplication
- clr  in  1  one-cycle pulse: abort, clear pointers and flags
- mul_done  in  1  multiplier completion pulse
- op_we  out  1  operand register write enable (registered)
- op_sel  out  1  operand written (registered)
- op_idx  out  PW  word index written (registered)
- op_wdata  out  WORD_W  word written (registered)
- mul_start  out  1  one-cycle start pulse to the multiplier
- in_ready  out  1  input words are accepted in the current state
- busy  out  1  multiplication in progress
- res_valid  out  1  product valid and current
- err  out  1  timeout occurred
- cur_ptr  out  PW  next write index of the selected operand, for display

## Operation
- States: IDLE, START, WAIT, DONE, ERR. The reset state is IDLE.
- in_ready = 1 in IDLE, DONE and ERR. busy = 1 in START and WAIT.
- Two write pointers, ptr0 and ptr1, each PW bits. cur_ptr = ptr[in_sel].
- Word accept (in_valid while in_ready):
  - Next cycle: op_we = 1, op_sel = in_sel, op_idx = ptr[in_sel], op_wdata = in_value.
  - ptr[in_sel] increments, wrapping from OP_WORDS-1 to 0.
  - Accepting a word in DONE or ERR moves to IDLE and clears res_valid and err.
- in_valid while in START or WAIT is dropped: no write, pointers unchanged.
- in_sel change, detected against its registered copy: the pointer of the newly selected operand resets to 0.
  - If in_valid arrives in the same cycle, the word goes to index 0 of the new operand and that pointer becomes 1.
- go in IDLE, DONE or ERR: move to START, clear res_valid and err. go in START or WAIT is ignored.
- START lasts one cycle with mul_start = 1, then moves to WAIT. A timeout counter clears to 0 on entry to WAIT.
- mul_done sampled in START or WAIT: move to DONE, res_valid = 1.
- In WAIT the counter increments every cycle. When the counter equals TIMEOUT_CYC-1 with no mul_done: move to ERR, err = 1.
  - If mul_done arrives in that same cycle, mul_done wins and the state goes to DONE.
- mul_done in IDLE, DONE or ERR is ignored.
- clr, in any state, has top priority over go, in_valid and mul_done:
  - state goes to IDLE; ptr0 and ptr1 go to 0; res_valid and err go to 0; the timeout counter goes to 0.
  - No op_we is issued for an in_valid arriving in the same cycle.
  - mul_done arriving after the abort is ignored.
- If go and in_valid arrive in the same cycle in an accepting state: the word is written, then the state moves to START.

## Timing
- Reset values: every output is 0, except in_ready = 1 (state IDLE). ptr0, ptr1 and the counter are 0.
- Word write: in_valid sampled at edge T gives op_we high for exactly the cycle after T. Throughput is one word per cycle.
- Start: go sampled at edge T gives mul_start high in the cycle after T (START); WAIT begins one cycle later.
- Completion: mul_done sampled at edge D gives res_valid = 1 and busy = 0 from the cycle after D.
- Timeout: ERR is entered TIMEOUT_CYC cycles after entering WAIT.
- An async resetn assertion mid-operation forces reset values immediately. No mul_start is issued after reset release until the next go.

## Test plan
- Reset, then 3 in_valid pulses with in_sel = 0 and values 0x11, 0x22, 0x33 -> op_we/op_idx give 0/0x11, 1/0x22, 2/0x33 on op_sel = 0; cur_ptr = 3.
- 33 consecutive words on In2 -> the 33rd word writes op_idx = 0 (wrap); cur_ptr = 1.
- Toggle in_sel 0 -> 1 -> 0 together with in_valid -> each word is written to index 0 of the newly selected operand.
- go, then mul_done 10 cycles after mul_start -> mul_start is a single cycle, busy = 1 for 11 cycles, res_valid = 1, in_valid is dropped while busy. A new word in DONE clears res_valid.
- go with no mul_done and TIMEOUT_CYC = 16 -> err = 1 exactly 16 cycles after entering WAIT. A second run with mul_done on the expiry cycle ends in DONE with err = 0.
- clr during WAIT, then mul_done -> state is IDLE, res_valid = 0, pointers = 0. resetn pulsed mid-WAIT -> all outputs at reset values.
